// File: rtl/tx_drain.sv
// rtl/tx_drain.sv - transmit buffer reader: walks rptr up to wr_ptr and hands bytes to uart_tx
// Optional macro TX_DRAIN_CNT_EN adds the sent_cnt handshake counter port.
module tx_drain #(
    parameter int AW    = 20,
    parameter int DEPTH = 200001,
    parameter int GAP   = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] buf_ra,
    input  logic [7:0]    buf_rd,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          empty
`ifdef TX_DRAIN_CNT_EN
    ,
    output logic [31:0]   sent_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]    GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    logic [1:0]    state;
    logic [AW-1:0] rptr;
    logic [7:0]    gap_cnt;

    assign buf_ra = rptr;
    assign empty  = (rptr == wr_ptr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            rptr     <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            gap_cnt  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The buffer read port bypasses same-cycle writes, so buf_rd is current.
                    if (!empty) begin
                        tx_data  <= buf_rd;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        rptr     <= (rptr == LAST_ADDR) ? '0 : rptr + AW'(1);
                        tx_valid <= 1'b0;
                        if (GAP > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TX_DRAIN_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sent_cnt <= 32'd0;
        end else if (tx_valid && tx_ready) begin
            sent_cnt <= sent_cnt + 32'd1;
        end
    end
`endif

endmodule
